// File: rtl/dlx_decode_if.sv
// Decode-stage bus: upstream instruction handshake, downstream operand
// outputs to the execute stage, and the writeback port into the register file.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. The producer holds instr stable while in_valid=1 and
// the transfer has not happened. Toward execute, enable_ex=1 marks a valid op;
// the op is taken on an edge where ex_stall=0, and while ex_stall=1 every
// output holds.
interface dlx_decode_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic          ex_stall;
    logic          enable_ex;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [DW-1:0] imm;
    logic [6:0]    control_out;
    logic [AW-1:0] rd_out;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    // Environment side: drives instructions, stall and writeback.
    modport master (
        output in_valid, instr, ex_stall, wb_en, wb_addr, wb_data,
        input  in_ready, enable_ex, src1, src2, imm, control_out, rd_out
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instr, ex_stall, wb_en, wb_addr, wb_data,
        output in_ready, enable_ex, src1, src2, imm, control_out, rd_out
    );
endinterface

// File: rtl/dlx_decode_stage.sv
// DLX decode / operand-fetch stage. Decodes one instruction per cycle, reads
// the owned 32x32 register file (with write-through bypass from the
// writeback port), stalls on RAW/WAW hazards through a per-register pending
// scoreboard, and holds the decoded op in an output register for execute.
module dlx_decode_stage #(
    parameter int DW    = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    dlx_decode_if.slave   bus
);

    // ALU operation codes as seen by the execute stage.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]    f_op;
    logic [AW-1:0] f_rs1;
    logic [AW-1:0] f_f2;
    logic [AW-1:0] f_rd_r;
    logic [5:0]    f_func;
    logic [15:0]   f_imm16;

    assign f_op    = bus.instr[31:26];
    assign f_rs1   = bus.instr[25:21];
    assign f_f2    = bus.instr[20:16];
    assign f_rd_r  = bus.instr[15:11];
    assign f_func  = bus.instr[5:0];
    assign f_imm16 = bus.instr[15:0];

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic          dec_legal;
    logic          dec_use_a;
    logic          dec_use_b;
    logic          dec_reg_wr;
    logic          dec_imm_sel;
    logic          dec_mem_rd;
    logic          dec_mem_wr;
    logic [2:0]    dec_alu;
    logic [AW-1:0] dec_dst;
    logic [DW-1:0] dec_imm;

    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_zext;
    logic [DW-1:0] imm_high;

    assign imm_sext = {{(DW-16){f_imm16[15]}}, f_imm16};
    assign imm_zext = DW'(f_imm16);
    assign imm_high = DW'({f_imm16, 16'h0000});

    // Decode opcode/func into execute controls and register usage.
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_a   = 1'b0;
        dec_use_b   = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_imm_sel = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_alu     = ALU_ADD;
        dec_dst     = '0;
        dec_imm     = '0;
        unique case (f_op)
            OP_RTYPE: begin
                dec_legal  = 1'b1;
                dec_use_a  = 1'b1;
                dec_use_b  = 1'b1;
                dec_reg_wr = 1'b1;
                dec_dst    = f_rd_r;
                case (f_func)
                    6'h20:   dec_alu = ALU_ADD;
                    6'h22:   dec_alu = ALU_SUB;
                    6'h24:   dec_alu = ALU_AND;
                    6'h25:   dec_alu = ALU_OR;
                    6'h26:   dec_alu = ALU_XOR;
                    6'h04:   dec_alu = ALU_SLL;
                    6'h06:   dec_alu = ALU_SRL;
                    6'h2A:   dec_alu = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW: begin
                dec_legal   = 1'b1;
                dec_use_a   = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_imm_sel = 1'b1;
                dec_dst     = f_f2;
                dec_imm     = imm_sext;
                dec_mem_rd  = (f_op == OP_LW);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_legal   = 1'b1;
                dec_use_a   = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_imm_sel = 1'b1;
                dec_dst     = f_f2;
                dec_imm     = imm_zext;
                dec_alu     = (f_op == OP_ANDI) ? ALU_AND :
                              (f_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_SW: begin
                // f2 names the store-data source, not a destination.
                dec_legal   = 1'b1;
                dec_use_a   = 1'b1;
                dec_use_b   = 1'b1;
                dec_imm_sel = 1'b1;
                dec_mem_wr  = 1'b1;
                dec_imm     = imm_sext;
            end
            OP_LHI: begin
                // rs1 is forced to r0, so no source register is read.
                dec_legal   = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_imm_sel = 1'b1;
                dec_dst     = f_f2;
                dec_imm     = imm_high;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file and operand read
    // ------------------------------------------------------------------
    logic [DW-1:0] rf [NREGS];
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          wb_live;

    // A writeback to r0 has no architectural effect anywhere in the stage.
    assign wb_live = bus.wb_en && (bus.wb_addr != '0);

    // Register file write; r0 is never written and stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_live) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Operand read with write-through bypass of the same-cycle writeback.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (dec_use_a && (f_rs1 != '0)) begin
            rd_a = (wb_live && (bus.wb_addr == f_rs1)) ? bus.wb_data : rf[f_rs1];
        end
        if (dec_use_b && (f_f2 != '0)) begin
            rd_b = (wb_live && (bus.wb_addr == f_f2)) ? bus.wb_data : rf[f_f2];
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard and hazard detection
    // ------------------------------------------------------------------
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pend_eff;
    logic             hazard;
    logic             adv;
    logic             accept;
    logic             issue;

    assign clr_mask = wb_live ? (NREGS'(1) << bus.wb_addr) : '0;
    assign pend_eff = pending & ~clr_mask;

    // A hazard only counts against the pending state left after this
    // cycle's writeback, so a source being written back now issues now.
    always_comb begin
        hazard = 1'b0;
        if (dec_legal) begin
            if (dec_use_a && pend_eff[f_rs1]) hazard = 1'b1;
            if (dec_use_b && pend_eff[f_f2]) hazard = 1'b1;
            if (dec_reg_wr && (dec_dst != '0) && pend_eff[dec_dst]) hazard = 1'b1;
        end
    end

    assign adv          = !bus.enable_ex || !bus.ex_stall;
    assign bus.in_ready = !rst && adv && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;
    // Unsupported encodings are consumed but never reach execute.
    assign issue        = accept && dec_legal;

    assign set_mask = (issue && dec_reg_wr && (dec_dst != '0)) ?
                      (NREGS'(1) << dec_dst) : '0;

    // Pending bits: clear on writeback, set on issue; set wins on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register toward execute
    // ------------------------------------------------------------------
    // Loads on advance; holds everything while execute is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.enable_ex   <= 1'b0;
            bus.src1        <= '0;
            bus.src2        <= '0;
            bus.imm         <= '0;
            bus.control_out <= '0;
            bus.rd_out      <= '0;
        end else if (adv) begin
            bus.enable_ex <= issue;
            if (issue) begin
                bus.src1        <= rd_a;
                bus.src2        <= rd_b;
                bus.imm         <= dec_imm;
                bus.control_out <= {dec_mem_wr, dec_mem_rd, dec_imm_sel,
                                    dec_reg_wr, dec_alu};
                bus.rd_out      <= dec_dst;
            end
        end
    end

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Bench for dlx_decode_stage: directed scenarios followed by random traffic,
// checked against a cycle-level reference model of the ISA, register file
// and pending scoreboard. Expected ops go into a queue at accept time; an
// independent monitor pops them when execute takes an op.
module tb_dlx_decode_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int W  = 3 * DW + 7 + AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dlx_decode_if #(.DW(DW), .AW(AW)) bus ();

    dlx_decode_stage #(.DW(DW), .NREGS(32), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];

    // Reference model state: architectural registers, pending flags and
    // whether execute currently sees a valid op.
    logic [31:0] m_regs[32];
    bit          m_pend[32];
    bit          m_en;

    typedef struct packed {
        logic        legal;
        logic        ua;
        logic        ub;
        logic        wr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  ctrl;
    } dec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics written from the ISA table.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        logic [5:0] op;
        logic [5:0] fn;
        int alu;
        bit is_imm;
        bit mrd;
        bit mwr;
        op = w[31:26];
        fn = w[5:0];
        alu = -1;
        is_imm = 0;
        mrd = 0;
        mwr = 0;
        d = '0;
        d.a = w[25:21];
        d.b = w[20:16];
        if (op == 6'h00) begin
            case (fn)
                6'h20: alu = 0;
                6'h22: alu = 1;
                6'h24: alu = 2;
                6'h25: alu = 3;
                6'h26: alu = 4;
                6'h04: alu = 5;
                6'h06: alu = 6;
                6'h2A: alu = 7;
                default: alu = -1;
            endcase
            if (alu >= 0) begin
                d.legal = 1; d.ua = 1; d.ub = 1; d.wr = 1; d.rd = w[15:11];
            end
        end else begin
            case (op)
                6'h08: begin alu = 0; d.imm = {{16{w[15]}}, w[15:0]}; end
                6'h0C: begin alu = 2; d.imm = {16'h0, w[15:0]}; end
                6'h0D: begin alu = 3; d.imm = {16'h0, w[15:0]}; end
                6'h0E: begin alu = 4; d.imm = {16'h0, w[15:0]}; end
                6'h23: begin alu = 0; d.imm = {{16{w[15]}}, w[15:0]}; mrd = 1; end
                6'h2B: begin alu = 0; d.imm = {{16{w[15]}}, w[15:0]}; mwr = 1; end
                6'h0F: begin alu = 0; d.imm = {w[15:0], 16'h0}; end
                default: alu = -1;
            endcase
            if (alu >= 0) begin
                d.legal = 1;
                is_imm  = 1;
                d.ua    = (op != 6'h0F);
                d.ub    = (op == 6'h2B);
                d.wr    = (op != 6'h2B);
                d.rd    = d.wr ? w[20:16] : 5'd0;
                if (op == 6'h0F) d.a = 5'd0;
            end
        end
        if (alu < 0) alu = 0;
        d.ctrl = {mwr, mrd, is_imm, d.wr, 3'(alu)};
        return d;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    function automatic bit m_busy(input logic [4:0] r, input bit we, input logic [4:0] wa);
        return m_pend[r] && !(we && wa == r);
    endfunction

    // One clock cycle: drive just after a rising edge, evaluate the model
    // and check handshake outputs after the falling edge, then advance.
    task automatic step(input bit v, input logic [31:0] w, input bit stall,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        output bit acc);
        dec_t d;
        bit adv;
        bit haz;
        bit exp_rdy;
        logic [31:0] s1;
        logic [31:0] s2;
        bus.in_valid = v;
        bus.instr    = w;
        bus.ex_stall = stall;
        bus.wb_en    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        @(negedge clk);
        #1;
        d = ref_decode(w);
        adv = !m_en || !stall;
        haz = d.legal && ((d.ua && m_busy(d.a, we, wa)) ||
                          (d.ub && m_busy(d.b, we, wa)) ||
                          (d.wr && d.rd != 5'd0 && m_busy(d.rd, we, wa)));
        exp_rdy = !rst && adv && !haz;
        check("enable_ex", W'(bus.enable_ex), W'(m_en));
        check("in_ready", W'(bus.in_ready), W'(exp_rdy));
        acc = v && exp_rdy;
        if (rst) begin
            m_en = 0;
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 0;
                m_regs[i] = 32'h0;
            end
            exp_q.delete();
            mask_q.delete();
        end else begin
            if (acc && d.legal) begin
                s1 = d.ua ? m_read(d.a, we, wa, wd) : 32'h0;
                s2 = m_read(d.b, we, wa, wd);
                exp_q.push_back({s1, s2, d.imm, d.ctrl, d.rd});
                mask_q.push_back({32'hFFFFFFFF, d.ub ? 32'hFFFFFFFF : 32'h0,
                                  d.ctrl[4] ? 32'hFFFFFFFF : 32'h0, 7'h7F,
                                  d.wr ? 5'h1F : 5'h00});
            end
            if (we && wa != 5'd0) m_regs[wa] = wd;
            if (we) m_pend[wa] = 0;
            if (acc && d.legal && d.wr && d.rd != 5'd0) m_pend[d.rd] = 1;
            m_pend[0] = 0;
            if (adv) m_en = acc && d.legal;
        end
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until accepted, with a bounded wait.
    task automatic issue(input logic [31:0] w);
        bit acc;
        acc = 0;
        for (int t = 0; t < 40 && !acc; t++) begin
            step(1, w, 0, 0, 5'd0, 32'h0, acc);
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: instr %h never accepted", w);
        end
    endtask

    task automatic idle_wb(input logic [4:0] wa, input logic [31:0] wd);
        bit acc;
        step(0, 32'h0, 0, 1, wa, wd, acc);
    endtask

    // Monitor: compares each op as execute takes it and checks that a
    // stalled op holds every output.
    logic [W-1:0] prev_out;
    bit           prev_hold = 0;
    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] e;
        logic [W-1:0] m;
        cur = {bus.src1, bus.src2, bus.imm, bus.control_out, bus.rd_out};
        if (prev_hold) begin
            check("hold_en", W'(bus.enable_ex), W'(1));
            check("hold_data", cur, prev_out);
        end
        if (bus.enable_ex === 1'b1 && bus.ex_stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL issue_unexpected: got %h expected no op", cur);
            end else begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                check("issue", cur & m, e & m);
            end
        end
        prev_hold = (bus.enable_ex === 1'b1) && (bus.ex_stall === 1'b1) && !rst;
        prev_out  = cur;
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0] ra, rb, rc;
        logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h2A};
        logic [5:0] iops[7] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h0F};
        logic [5:0] bad[3] = '{6'h3F, 6'h01, 6'h15};
        int k;
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        rc = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        if (k < 4) return {6'h00, ra, rb, rc, 5'd0, fns[$urandom_range(0, 7)]};
        if (k < 8) return {iops[$urandom_range(0, 6)], ra, rb, 16'($urandom)};
        if (k == 8) return {6'h00, ra, rb, rc, 5'd0, 6'h3F};
        return {bad[$urandom_range(0, 2)], ra, rb, 16'($urandom)};
    endfunction

    initial begin
        bit acc;
        bit hold;
        logic [31:0] cur_w;
        logic [4:0] plist[$];
        bit v, st, we;
        logic [4:0] wa;

        bus.in_valid = 0; bus.instr = 0; bus.ex_stall = 0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        m_en = 0;
        for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_regs[i] = 0; end
        rst = 1;
        @(posedge clk); #1;

        // Reset: two cycles with a valid instruction offered.
        step(1, 32'h2003FFFB, 0, 0, 5'd0, 32'h0, acc);
        step(1, 32'h2003FFFB, 0, 0, 5'd0, 32'h0, acc);
        rst = 0;
        check("reset_out", {bus.src1, bus.src2, bus.imm, bus.control_out, bus.rd_out}, '0);

        // ADDI r3,r0,-5 then ADD r4,r3,r3 waiting for r3 writeback.
        issue(32'h2003FFFB);
        step(1, {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20}, 0, 0, 5'd0, 32'h0, acc);
        step(1, {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20}, 0, 0, 5'd0, 32'h0, acc);
        step(1, {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20}, 0, 1, 5'd3, 32'hFFFFFFFB, acc);
        idle_wb(5'd4, 32'hFFFFFFF6);

        // ORI r1,r0,0x8000 and LHI r2,0x1234 back to back.
        issue({6'h0D, 5'd0, 5'd1, 16'h8000});
        issue({6'h0F, 5'd0, 5'd2, 16'h1234});
        idle_wb(5'd1, 32'h00008000);
        idle_wb(5'd2, 32'h12340000);

        // Downstream stall held three cycles over a valid op.
        issue({6'h08, 5'd0, 5'd6, 16'd100});
        for (int i = 0; i < 3; i++) step(1, {6'h0C, 5'd0, 5'd7, 16'h000F}, 1, 0, 5'd0, 32'h0, acc);
        step(1, {6'h0C, 5'd0, 5'd7, 16'h000F}, 0, 0, 5'd0, 32'h0, acc);
        idle_wb(5'd6, 32'h00000100);
        idle_wb(5'd7, 32'h0000000F);

        // SW r5,8(r6) with r5 written back in the same cycle.
        step(1, {6'h2B, 5'd6, 5'd5, 16'd8}, 0, 1, 5'd5, 32'hDEADBEEF, acc);

        // Unsupported opcode and func, then r0 write ignored.
        issue(32'hFC000000);
        issue({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h3F});
        idle_wb(5'd0, 32'h00001234);
        issue({6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h20});
        idle_wb(5'd8, 32'h0);

        // Reset while execute is stalled on a held op.
        issue({6'h08, 5'd1, 5'd9, 16'h0042});
        step(1, {6'h08, 5'd9, 5'd10, 16'h0001}, 1, 0, 5'd0, 32'h0, acc);
        rst = 1;
        step(1, {6'h08, 5'd9, 5'd10, 16'h0001}, 1, 0, 5'd0, 32'h0, acc);
        rst = 0;
        check("reset_mid_stall", {bus.src1, bus.src2, bus.imm, bus.control_out, bus.rd_out}, '0);

        // Random traffic; instr held while offered and not yet accepted.
        hold = 0;
        cur_w = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) cur_w = rand_instr();
            v  = hold || ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 3) == 0);
            plist.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) plist.push_back(5'(r));
            we = 0; wa = 0;
            if (plist.size() > 0 && $urandom_range(0, 1) == 1) begin
                we = 1; wa = plist[$urandom_range(0, plist.size() - 1)];
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1; wa = 5'($urandom_range(0, 7));
            end
            step(v, cur_w, st, we, wa, $urandom, acc);
            hold = v && !acc;
        end

        // Drain remaining work with bounded cycles.
        for (int c = 0; c < 60 && (exp_q.size() != 0 || m_en); c++) begin
            step(0, 32'h0, 0, 0, 5'd0, 32'h0, acc);
        end
        check("drain_empty", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
